// File: rtl/lsu_stage.sv
// Load/store unit stage: accepts one memory op from EX, runs a single bus transaction, returns extended load data.
// Optional misalignment trap is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_dmtype,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        we_q, we_d;
  logic [2:0]  dmtype_q, dmtype_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        misalign_s;

  // Access size: 0 = byte, 1 = halfword, 2 = word (reserved encodings are words)
  function automatic logic [1:0] size_f(input logic [2:0] dmtype);
    logic [1:0] sz;
    case (dmtype)
      3'b000, 3'b100: sz = 2'd0;
      3'b001, 3'b101: sz = 2'd1;
      default:        sz = 2'd2;
    endcase
    return sz;
  endfunction

  function automatic logic [3:0] be_f(input logic [2:0] dmtype, input logic [1:0] a);
    logic [3:0] be;
    case (size_f(dmtype))
      2'd0:    be = 4'b0001 << a;
      2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_f(input logic [2:0] dmtype, input logic [31:0] wd);
    logic [31:0] w;
    case (size_f(dmtype))
      2'd0:    w = {4{wd[7:0]}};
      2'd1:    w = {2{wd[15:0]}};
      default: w = wd;
    endcase
    return w;
  endfunction

  // Lane select then sign/zero extension; dmtype[2] marks the unsigned variants
  function automatic logic [31:0] load_f(input logic [2:0] dmtype, input logic [1:0] a,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{a, 3'b000} +: 8];
    h = rd[{a[1], 4'b0000} +: 16];
    case (size_f(dmtype))
      2'd0:    r = dmtype[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    r = dmtype[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  function automatic logic misalign_f(input logic [2:0] dmtype, input logic [1:0] a);
    logic m;
    case (size_f(dmtype))
      2'd1:    m = a[0];
      2'd2:    m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  assign misalign_s = misalign_f(req_dmtype, req_addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    we_d        = we_q;
    dmtype_d    = dmtype_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_lo_d = req_addr[1:0];
          we_d      = req_we;
          dmtype_d  = req_dmtype;
          if (misalign_s) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d     = ST_BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = be_f(req_dmtype, req_addr[1:0]);
            mem_wdata_d = req_we ? wdata_f(req_dmtype, req_wdata) : 32'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'd0 : load_f(dmtype_q, addr_lo_q, mem_rdata);
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_be_d    = 4'd0;
          mem_wdata_d = 32'd0;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured request fields and registered bus/response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lo_q   <= 2'd0;
      we_q        <= 1'b0;
      dmtype_q    <= 3'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      addr_lo_q   <= addr_lo_d;
      we_q        <= we_d;
      dmtype_q    <= dmtype_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed cases, randomized ops against a byte-lane model, reset and back-to-back.
module tb_lsu_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_dmtype;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wdata, last_addr, last_rdata;
  logic        last_err, saw_req;

  lsu_stage dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_dmtype(req_dmtype), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: access width in bytes and aligned byte offset
  function automatic int size_bytes(input logic [2:0] dt);
    if (dt == 3'd0 || dt == 3'd4) return 1;
    if (dt == 3'd1 || dt == 3'd5) return 2;
    return 4;
  endfunction

  task automatic do_op(input logic we, input logic [2:0] dt, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int w);
    int sz, off;
    logic [31:0] mask, val, exp_wd;
    logic [3:0] exp_be;
    bit mis;
    sz   = size_bytes(dt);
    off  = int'(a[1:0]) & ~(sz - 1);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    val  = (rd >> (8 * off)) & mask;
    if (!dt[2] && sz < 4 && (val & ((mask >> 1) + 32'd1)) != 32'd0) val = val | ~mask;
    if (we) val = 32'd0;
    exp_be = 4'(((1 << sz) - 1) << off);
    exp_wd = !we ? 32'd0 : (sz == 1) ? (wd & mask) * 32'h0101_0101 :
             (sz == 2) ? (wd & mask) * 32'h0001_0001 : wd;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = (int'(a[1:0]) % sz) != 0;
`else
    mis = 1'b0;
`endif
    saw_req = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL op_ready: got %b want 1", req_ready); end
    req_valid = 1'b1; req_we = we; req_dmtype = dt; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    if (mis) begin
      checks++;
      if (mem_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
        errors++;
        $display("FAIL misalign_rsp: req=%b valid=%b err=%b rdata=%h want 0 1 1 0", mem_req, rsp_valid, rsp_err, rsp_rdata);
      end
      last_err = rsp_err;
      last_rdata = rsp_rdata;
    end else begin
      for (int i = 0; i <= w; i++) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== {a[31:2], 2'b00} ||
            mem_be !== exp_be || mem_wdata !== exp_wd) begin
          errors++;
          $display("FAIL bus_out: req=%b we=%b addr=%h be=%b wd=%h want 1 %b %h %b %h",
                   mem_req, mem_we, mem_addr, mem_be, mem_wdata, we, {a[31:2], 2'b00}, exp_be, exp_wd);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL early_rsp: got %b want 0", rsp_valid); end
        saw_req = saw_req | mem_req;
        last_be = mem_be; last_wdata = mem_wdata; last_addr = mem_addr;
        mem_rdata = (i == w) ? rd : $urandom;
        mem_ack = (i == w);
        @(negedge clk);
      end
      mem_ack = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== val || rsp_err !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rsp: valid=%b rdata=%h err=%b req=%b want 1 %h 0 0", rsp_valid, rsp_rdata, rsp_err, mem_req, val);
      end
      last_err = rsp_err;
      last_rdata = rsp_rdata;
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_one_cycle: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_dmtype = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 ||
        mem_be !== 4'd0 || mem_wdata !== 32'd0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b req=%b we=%b addr=%h be=%b wd=%h rv=%b rd=%h err=%b want all 0",
               req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_directed();
    do_op(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 2);
    checks++;
    if (last_be !== 4'b1000 || last_rdata !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_case: be=%b rdata=%h want 1000 ffffff80", last_be, last_rdata);
    end
    do_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 1);
    checks++;
    if (last_addr !== 32'h0000_2000 || last_be !== 4'b1100 || last_wdata !== 32'hABCD_ABCD) begin
      errors++; $display("FAIL sh_case: addr=%h be=%b wd=%h want 00002000 1100 abcdabcd", last_addr, last_be, last_wdata);
    end
    do_op(1'b0, 3'b101, 32'h0000_0000, 32'd0, 32'h0000_F00F, 0);
    checks++;
    if (last_rdata !== 32'h0000_F00F) begin errors++; $display("FAIL lhu_case: got %h want 0000f00f", last_rdata); end
    do_op(1'b0, 3'b001, 32'h0000_0000, 32'd0, 32'h0000_F00F, 0);
    checks++;
    if (last_rdata !== 32'hFFFF_F00F) begin errors++; $display("FAIL lh_case: got %h want fffff00f", last_rdata); end
    do_op(1'b0, 3'b010, 32'h0000_1002, 32'd0, 32'hCAFE_0001, 1);
    checks++;
`ifdef LSU_MISALIGN_CHECK_EN
    if (saw_req !== 1'b0 || last_err !== 1'b1) begin
      errors++; $display("FAIL lw_misalign: saw_req=%b err=%b want 0 1", saw_req, last_err);
    end
`else
    if (last_addr !== 32'h0000_1000 || last_be !== 4'b1111 || last_err !== 1'b0) begin
      errors++; $display("FAIL lw_unaligned: addr=%h be=%b err=%b want 00001000 1111 0", last_addr, last_be, last_err);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_dmtype = 3'b010; req_addr = 32'h0000_0040;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rstbusy_req: got %b want 1", mem_req); end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rstbusy_ready_in_rst: got %b want 0", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'd0 || mem_be !== 4'd0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstbusy_clear: req=%b addr=%h be=%b rv=%b want 0 0 0 0", mem_req, mem_addr, mem_be, rsp_valid);
    end
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL rstbusy_late_ack: rv=%b req=%b ready=%b want 0 0 1", rsp_valid, mem_req, req_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_dmtype = 3'b010; req_addr = 32'h0000_0100; req_wdata = 32'd0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h0000_0200; req_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req_ready !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0100) begin
        errors++; $display("FAIL b2b_hold: ready=%b req=%b we=%b addr=%h want 0 1 0 00000100", req_ready, mem_req, mem_we, mem_addr);
      end
      mem_ack = (i == 1); mem_rdata = 32'h1122_3344;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122_3344 || req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_rsp1: rv=%b rd=%h ready=%b want 1 11223344 0", rsp_valid, rsp_rdata, req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: ready=%b rv=%b req=%b want 1 0 0", req_ready, rsp_valid, mem_req);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0000_0200 || mem_be !== 4'b1111 || mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_second: req=%b we=%b addr=%h be=%b wd=%h want 1 1 00000200 1111 deadbeef",
                         mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL b2b_rsp2: rv=%b rd=%h want 1 00000000", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
